// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded hold time and a one-cycle
// break-before-make gap between owners. State updates on the falling edge of c.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       c,
  input  logic       re_,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       busy,
  output logic [1:0] owner,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        ptr;
  logic [HOLD_W-1:0] hold;

  logic              pick_vld;
  logic [1:0]        pick_idx;
  logic              hold_max;
  logic              rel_drop;
  logic              rel_now;
  logic              rel_forced;

  // Search upward from p (mod 4); iterating from the farthest offset down
  // lets the nearest set bit overwrite the result last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    {pick_vld, pick_idx} = rr_pick(req, ptr);
  end

  assign hold_max   = (hold == HOLD_W'(MAX_HOLD));
  assign rel_drop   = ~req[owner];
  assign rel_now    = done | rel_drop | hold_max;
  // A timeout is reported only when the hold limit is the sole reason to let go.
  assign rel_forced = hold_max & ~done & ~rel_drop;

  always_ff @(negedge c or negedge re_) begin
    if (!re_) begin
      state   <= S_IDLE;
      ptr     <= 2'd0;
      hold    <= '0;
      grant   <= 4'b0000;
      busy    <= 1'b0;
      owner   <= 2'd0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE, S_GAP: begin
          if (pick_vld) begin
            grant <= 4'b0001 << pick_idx;
            owner <= pick_idx;
            busy  <= 1'b1;
            hold  <= HOLD_W'(1);
            state <= S_OWN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_OWN: begin
          if (rel_now) begin
            grant   <= 4'b0000;
            busy    <= 1'b0;
            ptr     <= owner + 2'd1;
            timeout <= rel_forced;
            state   <= S_GAP;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        default: begin
          grant <= 4'b0000;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: inputs change and outputs are sampled
// just after the rising edge, midway between active falling edges.
module tb_rr_arbiter4;

  logic       c;
  logic       re_;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter4 #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .c       (c),
    .re_     (re_),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  // All-requesting rotation, done pulsed on each owner's second cycle.
  logic [3:0] t2_g [14] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                            4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
  logic [1:0] t2_o [14] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                            2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
  logic       t2_d [14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                            1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance across exactly one falling edge, landing just after the next rising edge.
  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic do_reset();
    re_  = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    re_  = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    tick();
    check("rst_grant", 8'(grant), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_owner", 8'(owner), 8'h0);
    check("rst_timeout", 8'(timeout), 8'h0);

    // Test 1: first grant after reset release.
    re_ = 1'b1;
    req = 4'b0001;
    tick();
    check("t1_grant", 8'(grant), 8'h1);
    check("t1_owner", 8'(owner), 8'h0);
    check("t1_busy", 8'(busy), 8'h1);
    check("t1_timeout", 8'(timeout), 8'h0);

    // Test 2: fairness rotation with done on the second owned cycle.
    do_reset();
    re_ = 1'b1;
    req = 4'b1111;
    tick();
    for (int i = 0; i < 14; i++) begin
      check($sformatf("t2_grant[%0d]", i), 8'(grant), 8'(t2_g[i]));
      check($sformatf("t2_owner[%0d]", i), 8'(owner), 8'(t2_o[i]));
      check($sformatf("t2_busy[%0d]", i), 8'(busy), 8'(t2_g[i] != 4'b0000));
      check($sformatf("t2_timeout[%0d]", i), 8'(timeout), 8'h0);
      done = t2_d[i];
      tick();
    end
    done = 1'b0;

    // Test 3: forced release at MAX_HOLD, then sole requester re-granted.
    do_reset();
    re_ = 1'b1;
    req = 4'b0100;
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_grant[%0d]", i), 8'(grant), (i == 8) ? 8'h0 : 8'h4);
      check($sformatf("t3_timeout[%0d]", i), 8'(timeout), (i == 8) ? 8'h1 : 8'h0);
      tick();
    end

    // Test 4: done coinciding with the hold limit is a normal release.
    do_reset();
    re_ = 1'b1;
    req = 4'b0010;
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t4_grant[%0d]", i), 8'(grant), (i == 8) ? 8'h0 : 8'h2);
      check($sformatf("t4_timeout[%0d]", i), 8'(timeout), 8'h0);
      done = (i == 7);
      tick();
    end
    done = 1'b0;

    // Test 5: owner drops its request; pointer moves past it to requester 3.
    do_reset();
    re_ = 1'b1;
    req = 4'b0010;
    tick();
    check("t5_grant0", 8'(grant), 8'h2);
    req = 4'b1011;
    tick();
    check("t5_grant1", 8'(grant), 8'h2);
    check("t5_owner1", 8'(owner), 8'h1);
    req = 4'b1001;
    tick();
    check("t5_gap_grant", 8'(grant), 8'h0);
    check("t5_gap_busy", 8'(busy), 8'h0);
    check("t5_gap_timeout", 8'(timeout), 8'h0);
    check("t5_gap_owner", 8'(owner), 8'h1);
    tick();
    check("t5_grant3", 8'(grant), 8'h8);
    check("t5_owner3", 8'(owner), 8'h3);

    // Test 6: asynchronous reset mid-ownership, then restart from ptr=0.
    do_reset();
    re_ = 1'b1;
    req = 4'b0100;
    tick();
    check("t6_pre_grant", 8'(grant), 8'h4);
    check("t6_pre_owner", 8'(owner), 8'h2);
    #2;
    re_ = 1'b0;
    #1;
    check("t6_async_grant", 8'(grant), 8'h0);
    check("t6_async_busy", 8'(busy), 8'h0);
    check("t6_async_owner", 8'(owner), 8'h0);
    req = 4'b1001;
    tick();
    re_ = 1'b1;
    done = 1'b1;
    tick();
    check("t6_grant", 8'(grant), 8'h1);
    check("t6_owner", 8'(owner), 8'h0);
    check("t6_busy", 8'(busy), 8'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
